servo_cmd_ramp: RTL and testbench
=================================

// Module: servo_cmd_ramp
// PURPOSE
//   Upstream stage of the servo PWM generator: accepts position commands from the SoC bus via
//   valid/ready, slew-limits them, and drives the 8-bit dutty word into the servo PWM block.
//   Keeps the horn from jumping between extremes, and reports busy/done to software
//   once the horn has reached the target and the settle time has elapsed.
// PARAMETERS
//   TICK_DIV      1_000_000  clk cycles per ramp tick (20 ms at 50 MHz, one PWM frame)
//   STEP          4          max dutty change per tick (units of dutty LSB), 1..255
//   SETTLE_TICKS  5          ticks held in SETTLE after target reached, >=1
//   LIM_LO        10         soft lower limit (SERVO_SOFTLIMIT_EN only)
//   LIM_HI        170        soft upper limit (SERVO_SOFTLIMIT_EN only), LIM_LO<=LIM_HI<=POS_MAX
// PORTS
//   clk        in   1  system clock, 50 MHz
//   rst_n      in   1  asynchronous active-low reset
//   cmd_pos    in   8  requested position (0..POS_MAX)
//   cmd_valid  in   1  cmd_pos valid
//   cmd_ready  out  1  command can be accepted this cycle
//   dutty      out  8  position word to servo PWM block
//   busy       out  1  high whenever state != IDLE
//   done       out  1  one-cycle pulse on SETTLE->IDLE
//   limit_hit  out  1  one-cycle pulse when an accepted command was clamped (0 without macro)
// BEHAVIOUR
//   Reset (async, rst_n=0): dutty=HOME_POS(90), target=HOME_POS, state=IDLE, busy=0, done=0,
//     limit_hit=0, tick counter=0, settle counter=0. cmd_ready is combinational and =1 in IDLE.
//   Tick: free-running counter 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1.
//   Accept: cmd_valid&&cmd_ready at a rising edge; target <= sat(cmd_pos) at that edge.
//     sat(): cmd_pos>POS_MAX -> POS_MAX (always applied, no limit_hit for this alone).
//   cmd_ready = (state==IDLE)||(state==RAMP); 0 in SETTLE.
//   FSM:
//     IDLE   : accept with sat(cmd_pos)!=dutty -> RAMP; ==dutty -> SETTLE (settle cnt=SETTLE_TICKS).
//     RAMP   : on tick: d=target-dutty; dutty += sign(d)*min(STEP,|d|) (never overshoots);
//              if the new dutty==target -> SETTLE, settle cnt=SETTLE_TICKS.
//              Accept in RAMP retargets; ramp continues from current dutty, no restart.
//     SETTLE : on tick settle cnt--; when it reaches 0 -> IDLE and done=1 for that one cycle.
//   Latency: first dutty change on the first tick strictly after the accept edge.
//   Accept and tick in same cycle: that tick's step uses the old target; new target from next tick.
//   Retarget in RAMP onto the current dutty: the next tick moves by 0 and enters SETTLE.
//   Arithmetic: diff computed in 9-bit signed; dutty stays within [0,POS_MAX] at all times.
//   Reset mid-ramp: dutty returns to HOME_POS immediately (async); pending target discarded.
// CONFIGURATION
//   SERVO_SOFTLIMIT_EN defined: after sat(), target clamped to [LIM_LO,LIM_HI]; limit_hit pulses
//     one cycle on the accept edge if the clamp changed the value.
//   Undefined: only sat() to POS_MAX applies; limit_hit tied 0; LIM_* unused.
// STRUCTURE
//   servo_pkg: POS_MAX=180, HOME_POS=90, state enum {IDLE,RAMP,SETTLE}, sat/clamp functions.
//   Sub-module servo_tick_gen (TICK_DIV prescaler, async rst_n, one-cycle tick out);
//   FSM, target register and step arithmetic live in servo_cmd_ramp.
// TESTING (bench uses TICK_DIV=4, STEP=4, SETTLE_TICKS=2)
//   1 Reset: rst_n=0 -> dutty=90, busy=0, cmd_ready=1, done=0, limit_hit=0.
//   2 Ramp up: cmd 100 from 90 -> dutty 94,98,100 on successive ticks; SETTLE 2 ticks; done 1 cycle.
//   3 Saturate: cmd 255 (macro off) -> target 180, ramps to 180, limit_hit stays 0.
//   4 Retarget: ramp 90->150, at dutty=110 send cmd 100 -> 106,102,100, no overshoot, then done.
//   5 Handshake: cmd_valid held high in SETTLE -> cmd_ready=0, no accept until IDLE.
//   6 Macro on: cmd 5 -> target 10, limit_hit 1 cycle; rst_n low mid-ramp -> dutty=90 at once.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and position helpers for the servo command ramp.
package servo_pkg;

  localparam logic [7:0] POS_MAX  = 8'd180;
  localparam logic [7:0] HOME_POS = 8'd90;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } state_t;

  function automatic logic [7:0] sat(input logic [7:0] p);
    return (p > POS_MAX) ? POS_MAX : p;
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] p,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
    if (p < lo) return lo;
    if (p > hi) return hi;
    return p;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Ramp tick prescaler: one-cycle tick every TICK_DIV clocks.
module servo_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_cmd_ramp.sv
// Slew-limited servo position command stage (valid/ready in, dutty word out).
// Define SERVO_SOFTLIMIT_EN to clamp accepted targets to [LIM_LO,LIM_HI] and pulse limit_hit.
module servo_cmd_ramp
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1_000_000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned SETTLE_TICKS = 5,
  parameter int unsigned LIM_LO       = 10,
  parameter int unsigned LIM_HI       = 170
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_pos,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] dutty,
  output logic       busy,
  output logic       done,
  output logic       limit_hit
);

`ifdef SERVO_SOFTLIMIT_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  // With soft limits off the clamp window is the full range, so sat() alone applies.
  localparam logic [7:0] LO_EFF = SOFT_EN ? 8'(LIM_LO) : 8'd0;
  localparam logic [7:0] HI_EFF = SOFT_EN ? 8'(LIM_HI) : POS_MAX;

  localparam int unsigned SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_TICKS);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);

  state_t        state;
  logic [7:0]    target;
  logic [SW-1:0] settle_cnt;
  logic          tick;
  logic          accept;
  logic [7:0]    cmd_sat;
  logic [7:0]    cmd_eff;

  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [7:0]        stepv;
  logic [7:0]        dutty_next;

  servo_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign cmd_ready = (state == IDLE) || (state == RAMP);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_sat   = sat(cmd_pos);
  assign cmd_eff   = clamp(cmd_sat, LO_EFF, HI_EFF);

  always_comb begin
    diff       = $signed({1'b0, target}) - $signed({1'b0, dutty});
    mag        = diff[8] ? 9'(-diff) : 9'(diff);
    stepv      = (mag > STEP9) ? STEP8 : mag[7:0];
    dutty_next = diff[8] ? (dutty - stepv) : (dutty + stepv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dutty      <= HOME_POS;
      target     <= HOME_POS;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target <= cmd_eff;
            busy   <= 1'b1;
            if (cmd_eff == dutty) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (accept) begin
            target <= cmd_eff;
          end
          // A tick coinciding with a retarget steps toward the old target and keeps ramping.
          if (tick) begin
            dutty <= dutty_next;
            if (!accept && (dutty_next == target)) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (tick) begin
            if (settle_cnt <= 1) begin
              settle_cnt <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERVO_SOFTLIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_hit <= 1'b0;
    end else begin
      limit_hit <= accept && (cmd_eff != cmd_sat);
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Scoreboard bench for servo_cmd_ramp: expected dutty steps are queued when commands are sent.
module tb_servo_cmd_ramp;

  localparam int TD = 4;
  localparam int ST = 4;
  localparam int STL = 2;
  localparam int HOME = 90;
  localparam int PMAX = 180;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_pos = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] dutty;
  logic       busy;
  logic       done;
  logic       limit_hit;

  int n_vec = 0;
  int n_bad = 0;
  int cur = HOME;
  logic [7:0] expq[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_d = 8'd90;

  servo_cmd_ramp #(
    .TICK_DIV(TD),
    .STEP(ST),
    .SETTLE_TICKS(STL),
    .LIM_LO(10),
    .LIM_HI(170)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_pos  (cmd_pos),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .dutty    (dutty),
    .busy     (busy),
    .done     (done),
    .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  // Every change of dutty must match the next queued step.
  always @(negedge clk) begin
    if (mon_en && (dutty !== prev_d)) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL ramp_step: dutty=%0d, no step expected (prev %0d)", dutty, prev_d);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (dutty !== e) begin
          n_bad++;
          $display("FAIL ramp_step: dutty=%0d, expected %0d", dutty, e);
        end
      end
    end
    prev_d = dutty;
  end

  function automatic int exp_target(input int p);
    int t;
    t = (p > PMAX) ? PMAX : p;
`ifdef SERVO_SOFTLIMIT_EN
    if (t < 10) t = 10;
    if (t > 170) t = 170;
`endif
    return t;
  endfunction

  function automatic bit exp_lh(input int p);
    int s;
    s = (p > PMAX) ? PMAX : p;
    return exp_target(p) != s;
  endfunction

  task automatic push_ramp(input int from, input int to);
    int d;
    d = from;
    while (d != to) begin
      if (to > d) d = d + (((to - d) < ST) ? (to - d) : ST);
      else        d = d - (((d - to) < ST) ? (d - to) : ST);
      expq.push_back(8'(d));
    end
  endtask

  task automatic send_cmd(input int p);
    logic [7:0] pv;
    pv = 8'(p);
    @(negedge clk);
    cmd_pos = pv;
    cmd_valid = 1'b1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_ready: cmd_ready=%b, expected 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_vec++;
    if (limit_hit !== exp_lh(p)) begin
      n_bad++;
      $display("FAIL limit_hit: cmd=%0d limit_hit=%b, expected %b", p, limit_hit, exp_lh(p));
    end
  endtask

  task automatic wait_done(input int final_d, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) break;
    end
    n_vec++;
    if (i == budget) begin
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles, dutty=%0d expected %0d", budget, dutty, final_d);
    end else begin
      n_vec++;
      if (busy !== 1'b0 || dutty !== 8'(final_d)) begin
        n_bad++;
        $display("FAIL done_state: busy=%b dutty=%0d, expected busy=0 dutty=%0d", busy, dutty, final_d);
      end
      n_vec++;
      if (expq.size() != 0) begin
        n_bad++;
        $display("FAIL ramp_incomplete: %0d steps still pending, expected 0", expq.size());
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL done_pulse: done=%b one cycle later, expected 0", done);
      end
    end
    cur = final_d;
  endtask

  task automatic wait_dutty(input int v, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (dutty === 8'(v)) break;
    end
    n_vec++;
    if (i == budget) begin
      n_bad++;
      $display("FAIL wait_dutty: dutty=%0d, expected to reach %0d", dutty, v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (dutty !== 8'd90 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || limit_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: dutty=%0d busy=%b ready=%b done=%b lh=%b, expected 90 0 1 0 0",
               dutty, busy, cmd_ready, done, limit_hit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = dutty;
    mon_en = 1'b1;
    cur = HOME;
  endtask

  task automatic test_ramp_up();
    push_ramp(cur, exp_target(100));
    send_cmd(100);
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ramp_busy: busy=%b, expected 1", busy);
    end
    wait_done(exp_target(100), 100);
  endtask

  task automatic test_saturate();
    push_ramp(cur, exp_target(255));
    send_cmd(255);
    wait_done(exp_target(255), 500);
  endtask

  task automatic test_retarget();
    push_ramp(cur, 90);
    send_cmd(90);
    wait_done(90, 500);
    push_ramp(90, 110);
    send_cmd(150);
    wait_dutty(110, 200);
    push_ramp(110, 100);
    send_cmd(100);
    wait_done(100, 200);
  endtask

  task automatic test_handshake();
    int i;
    send_cmd(cur);
    n_vec++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL settle_ready: ready=%b busy=%b, expected 0 1", cmd_ready, busy);
    end
    cmd_pos = 8'd120;
    cmd_valid = 1'b1;
    for (i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) break;
      n_vec++;
      if (cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL settle_hold: ready=%b in settle, expected 0", cmd_ready);
      end
    end
    n_vec++;
    if (i == 60 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL settle_release: ready=%b after %0d cycles, expected 1 at done", cmd_ready, i);
    end
    push_ramp(cur, exp_target(120));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL held_accept: busy=%b, expected 1", busy);
    end
    wait_done(exp_target(120), 200);
  endtask

  task automatic test_limit_and_reset();
    push_ramp(cur, exp_target(5));
    send_cmd(5);
    @(posedge clk);
    #1;
    n_vec++;
    if (limit_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL limit_pulse: limit_hit=%b second cycle, expected 0", limit_hit);
    end
    wait_dutty(cur - 2 * ST, 100);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dutty !== 8'd90 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: dutty=%0d busy=%b, expected 90 0", dutty, busy);
    end
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = dutty;
    mon_en = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if (dutty !== 8'd90 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL target_discard: dutty=%0d busy=%b, expected 90 0", dutty, busy);
    end
    cur = HOME;
    push_ramp(cur, 95);
    send_cmd(95);
    wait_done(95, 100);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_saturate();
    test_retarget();
    test_handshake();
    test_limit_and_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
